// File: rtl/riscv_pkg.sv
// Shared RV32I decode encodings: opcodes, ALU/result-source selects, immediate formats,
// and the control/ID-EX bundles passed from decode to execute.
package riscv_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmJ    = 3'd4
    } imm_type_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        result_src_e result_src;
        alu_ctrl_e   alu_control;
    } ctrl_t;

    localparam ctrl_t CtrlNop = '{
        reg_write:   1'b0,
        mem_write:   1'b0,
        jump:        1'b0,
        branch:      1'b0,
        alu_src:     1'b0,
        result_src:  ResAlu,
        alu_control: AluAdd
    };

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_t;

    function automatic logic [31:0] imm_extend(input logic [31:0] instr, input imm_type_e imm_type);
        logic [31:0] imm;
        case (imm_type)
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 31x32 register file (x0 hard-wired to zero), two combinational read ports, one write port,
// with optional same-cycle write-back forwarding.
module reg_file #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] regs_q [31:1];
    logic [31:0] stored1, stored2;
    logic        hit1, hit2;
    logic        wr_en;

    assign wr_en = we_i && (wa_i != 5'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign stored1 = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign stored2 = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

    // wr_en already excludes x0, so a forwarded hit can never make x0 non-zero.
    assign hit1 = WB_BYPASS && wr_en && (wa_i == ra1_i);
    assign hit2 = WB_BYPASS && wr_en && (wa_i == ra2_i);

    assign rd1_o = hit1 ? wd_i : stored1;
    assign rd2_o = hit2 ? wd_i : stored2;

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction decode, immediate generation, register read and the ID/EX
// pipeline register with decode-kill and bubble-insert flushes.
module id_stage
    import riscv_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instruction_f,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_plus_4_f,
    input  logic        flush_d,
    input  logic        flush_e,
    input  logic        reg_write_w,
    input  logic [4:0]  rd_w,
    input  logic [31:0] result_w,
    output logic [4:0]  rs1_d,
    output logic [4:0]  rs2_d,
    output logic [31:0] rd1_e,
    output logic [31:0] rd2_e,
    output logic [31:0] imm_ext_e,
    output logic [31:0] pc_e,
    output logic [31:0] pc_plus_4_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        jump_e,
    output logic        branch_e,
    output logic        alu_src_e,
    output logic [1:0]  result_src_e,
    output logic [2:0]  alu_control_e
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rd1_d, rd2_d;
    ctrl_t       ctrl_d;
    imm_type_e   imm_type_d;
    alu_ctrl_e   alu_funct;
    idex_t       idex_d, idex_q;

    assign opcode   = instruction_f[6:0];
    assign funct3   = instruction_f[14:12];
    assign funct7b5 = instruction_f[30];
    assign rs1_d    = instruction_f[19:15];
    assign rs2_d    = instruction_f[24:20];

    reg_file #(
        .WB_BYPASS (WB_BYPASS)
    ) u_reg_file (
        .clk     (clk),
        .reset_n (reset_n),
        .ra1_i   (rs1_d),
        .ra2_i   (rs2_d),
        .we_i    (reg_write_w),
        .wa_i    (rd_w),
        .wd_i    (result_w),
        .rd1_o   (rd1_d),
        .rd2_o   (rd2_d)
    );

    // ALU op for R/I arithmetic; only R-type may turn add into sub via funct7[5].
    always_comb begin
        alu_funct = AluAdd;
        case (funct3)
            3'b000:  alu_funct = (opcode == OpRtype && funct7b5) ? AluSub : AluAdd;
            3'b010:  alu_funct = AluSlt;
            3'b110:  alu_funct = AluOr;
            3'b111:  alu_funct = AluAnd;
            default: alu_funct = AluAdd;
        endcase
    end

    always_comb begin
        ctrl_d     = CtrlNop;
        imm_type_d = ImmNone;
        case (opcode)
            OpLoad: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = ResMem;
                imm_type_d        = ImmI;
            end
            OpStore: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_type_d       = ImmS;
            end
            OpRtype: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_control = alu_funct;
            end
            OpItype: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = alu_funct;
                imm_type_d         = ImmI;
            end
            OpBranch: begin
                ctrl_d.branch      = 1'b1;
                ctrl_d.alu_control = AluSub;
                imm_type_d         = ImmB;
            end
            OpJal: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.result_src = ResPc4;
                imm_type_d        = ImmJ;
            end
            default: ;
        endcase
    end

    always_comb begin
        idex_d.ctrl      = ctrl_d;
        idex_d.rd1       = rd1_d;
        idex_d.rd2       = rd2_d;
        idex_d.imm_ext   = imm_extend(instruction_f, imm_type_d);
        idex_d.pc        = pc_f;
        idex_d.pc_plus_4 = pc_plus_4_f;
        idex_d.rs1       = rs1_d;
        idex_d.rs2       = rs2_d;
        idex_d.rd        = instruction_f[11:7];
        if (flush_e) begin
            idex_d = '0;
        end else if (flush_d) begin
            idex_d.ctrl = CtrlNop;
            idex_d.rd   = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign rd1_e         = idex_q.rd1;
    assign rd2_e         = idex_q.rd2;
    assign imm_ext_e     = idex_q.imm_ext;
    assign pc_e          = idex_q.pc;
    assign pc_plus_4_e   = idex_q.pc_plus_4;
    assign rs1_e         = idex_q.rs1;
    assign rs2_e         = idex_q.rs2;
    assign rd_e          = idex_q.rd;
    assign reg_write_e   = idex_q.ctrl.reg_write;
    assign mem_write_e   = idex_q.ctrl.mem_write;
    assign jump_e        = idex_q.ctrl.jump;
    assign branch_e      = idex_q.ctrl.branch;
    assign alu_src_e     = idex_q.ctrl.alu_src;
    assign result_src_e  = idex_q.ctrl.result_src;
    assign alu_control_e = idex_q.ctrl.alu_control;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: one DUT with write-back forwarding, one without, same stimulus.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instruction_f, pc_f, pc_plus_4_f;
    logic        flush_d, flush_e, reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;

    logic [4:0]  b_rs1_d, b_rs2_d, b_rs1_e, b_rs2_e, b_rd_e;
    logic [31:0] b_rd1_e, b_rd2_e, b_imm_ext_e, b_pc_e, b_pc_plus_4_e;
    logic        b_reg_write_e, b_mem_write_e, b_jump_e, b_branch_e, b_alu_src_e;
    logic [1:0]  b_result_src_e;
    logic [2:0]  b_alu_control_e;

    logic [4:0]  n_rs1_d, n_rs2_d, n_rs1_e, n_rs2_e, n_rd_e;
    logic [31:0] n_rd1_e, n_rd2_e, n_imm_ext_e, n_pc_e, n_pc_plus_4_e;
    logic        n_reg_write_e, n_mem_write_e, n_jump_e, n_branch_e, n_alu_src_e;
    logic [1:0]  n_result_src_e;
    logic [2:0]  n_alu_control_e;

    // {reg_write, mem_write, jump, branch, alu_src, result_src[1:0], alu_control[2:0]}
    logic [9:0]  ctrl;
    logic [9:0]  n_ctrl;
    assign ctrl   = {b_reg_write_e, b_mem_write_e, b_jump_e, b_branch_e, b_alu_src_e,
                     b_result_src_e, b_alu_control_e};
    assign n_ctrl = {n_reg_write_e, n_mem_write_e, n_jump_e, n_branch_e, n_alu_src_e,
                     n_result_src_e, n_alu_control_e};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_stage #(.WB_BYPASS(1'b1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instruction_f (instruction_f),
        .pc_f          (pc_f),
        .pc_plus_4_f   (pc_plus_4_f),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .reg_write_w   (reg_write_w),
        .rd_w          (rd_w),
        .result_w      (result_w),
        .rs1_d         (b_rs1_d),
        .rs2_d         (b_rs2_d),
        .rd1_e         (b_rd1_e),
        .rd2_e         (b_rd2_e),
        .imm_ext_e     (b_imm_ext_e),
        .pc_e          (b_pc_e),
        .pc_plus_4_e   (b_pc_plus_4_e),
        .rs1_e         (b_rs1_e),
        .rs2_e         (b_rs2_e),
        .rd_e          (b_rd_e),
        .reg_write_e   (b_reg_write_e),
        .mem_write_e   (b_mem_write_e),
        .jump_e        (b_jump_e),
        .branch_e      (b_branch_e),
        .alu_src_e     (b_alu_src_e),
        .result_src_e  (b_result_src_e),
        .alu_control_e (b_alu_control_e)
    );

    id_stage #(.WB_BYPASS(1'b0)) dut_nb (
        .clk           (clk),
        .reset_n       (reset_n),
        .instruction_f (instruction_f),
        .pc_f          (pc_f),
        .pc_plus_4_f   (pc_plus_4_f),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .reg_write_w   (reg_write_w),
        .rd_w          (rd_w),
        .result_w      (result_w),
        .rs1_d         (n_rs1_d),
        .rs2_d         (n_rs2_d),
        .rd1_e         (n_rd1_e),
        .rd2_e         (n_rd2_e),
        .imm_ext_e     (n_imm_ext_e),
        .pc_e          (n_pc_e),
        .pc_plus_4_e   (n_pc_plus_4_e),
        .rs1_e         (n_rs1_e),
        .rs2_e         (n_rs2_e),
        .rd_e          (n_rd_e),
        .reg_write_e   (n_reg_write_e),
        .mem_write_e   (n_mem_write_e),
        .jump_e        (n_jump_e),
        .branch_e      (n_branch_e),
        .alu_src_e     (n_alu_src_e),
        .result_src_e  (n_result_src_e),
        .alu_control_e (n_alu_control_e)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; instruction_f = 32'h0; pc_f = 32'h0; pc_plus_4_f = 32'h0;
        flush_d = 1'b0; flush_e = 1'b0; reg_write_w = 1'b0; rd_w = 5'd0; result_w = 32'h0;
        step();
        tests++;
        if ({ctrl, b_rd1_e, b_imm_ext_e, b_pc_e, b_rd_e} !== 111'd0) begin
            fails++; $display("FAIL reset_init: got %h want 0", {ctrl, b_rd1_e, b_imm_ext_e, b_pc_e});
        end
        #3 reset_n = 1'b1;
        // Write x5 while add x6,x5,x5 is presented.
        step();
        pc_f = 32'h40; pc_plus_4_f = 32'h44;
        instruction_f = 32'h00528333; reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'h55;
        step();
        reg_write_w = 1'b0;
        step();
        tests++;
        if (b_rd1_e !== 32'h55 || n_rd2_e !== 32'h55 || b_pc_e !== 32'h40) begin
            fails++; $display("FAIL x5_written: got %h/%h pc %h want 55/55 pc 40",
                              b_rd1_e, n_rd2_e, b_pc_e);
        end
        // Mid-cycle reset with a pending write to x7.
        #2 reset_n = 1'b0; reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'h77;
        #1;
        tests++;
        if ({ctrl, b_rd1_e, b_pc_e, b_pc_plus_4_e, b_rd_e, b_rs1_e} !== 116'd0) begin
            fails++; $display("FAIL reset_async: got ctrl %b rd1 %h pc %h want 0",
                              ctrl, b_rd1_e, b_pc_e);
        end
        step();
        reg_write_w = 1'b0;
        #2 reset_n = 1'b1;
        instruction_f = 32'h00728333;  // add x6,x5,x7
        step();
        tests++;
        if (b_rd1_e !== 32'h0 || b_rd2_e !== 32'h0 || n_rd1_e !== 32'h0 || b_rd_e !== 5'd6
            || ctrl !== 10'b1_0_0_0_0_00_000) begin
            fails++; $display("FAIL reset_regs: got x5 %h x7 %h rd %0d ctrl %b want 0 0 6 1000000000",
                              b_rd1_e, b_rd2_e, b_rd_e, ctrl);
        end
    endtask

    task automatic test_addi();
        instruction_f = 32'hFFB00093; pc_f = 32'h100; pc_plus_4_f = 32'h104;
        step();
        tests++;
        if (b_imm_ext_e !== 32'hFFFFFFFB || b_rd_e !== 5'd1 || ctrl !== 10'b1_0_0_0_1_00_000) begin
            fails++; $display("FAIL addi: got imm %h rd %0d ctrl %b want FFFFFFFB 1 1000100000",
                              b_imm_ext_e, b_rd_e, ctrl);
        end
        instruction_f = 32'h40018093;  // addi x1,x3,0x400 (bit30 set, still add)
        step();
        tests++;
        if (b_imm_ext_e !== 32'h400 || ctrl !== 10'b1_0_0_0_1_00_000 || b_rs1_e !== 5'd3) begin
            fails++; $display("FAIL addi_no_sub: got imm %h ctrl %b rs1 %0d want 400 1000100000 3",
                              b_imm_ext_e, ctrl, b_rs1_e);
        end
    endtask

    task automatic test_bypass();
        instruction_f = 32'h00000013; reg_write_w = 1'b1; rd_w = 5'd3; result_w = 32'h1111;
        step();
        instruction_f = 32'h00318233; result_w = 32'h1234;  // add x4,x3,x3
        #1;
        tests++;
        if (b_rs1_d !== 5'd3 || b_rs2_d !== 5'd3) begin
            fails++; $display("FAIL rs_d: got %0d %0d want 3 3", b_rs1_d, b_rs2_d);
        end
        step();
        reg_write_w = 1'b0;
        tests++;
        if (b_rd1_e !== 32'h1234 || b_rd2_e !== 32'h1234 || b_rd_e !== 5'd4
            || ctrl !== 10'b1_0_0_0_0_00_000) begin
            fails++; $display("FAIL bypass_on: got %h %h rd %0d ctrl %b want 1234 1234 4 1000000000",
                              b_rd1_e, b_rd2_e, b_rd_e, ctrl);
        end
        tests++;
        if (n_rd1_e !== 32'h1111 || n_rd2_e !== 32'h1111) begin
            fails++; $display("FAIL bypass_off: got %h %h want 1111 1111", n_rd1_e, n_rd2_e);
        end
        step();
        tests++;
        if (n_rd1_e !== 32'h1234) begin
            fails++; $display("FAIL wb_stored: got %h want 1234", n_rd1_e);
        end
    endtask

    task automatic test_rtype_alu();
        logic [31:0] ins [4] = '{32'h40318233, 32'h0031F233, 32'h0031E233, 32'h0031A233};
        logic [2:0]  exp [4] = '{3'b001, 3'b010, 3'b011, 3'b101};
        for (int i = 0; i < 4; i++) begin
            instruction_f = ins[i];
            step();
            tests++;
            if (b_alu_control_e !== exp[i] || b_reg_write_e !== 1'b1 || b_imm_ext_e !== 32'h0) begin
                fails++; $display("FAIL rtype_alu[%0d]: got alu %b rw %b imm %h want %b 1 0",
                                  i, b_alu_control_e, b_reg_write_e, b_imm_ext_e, exp[i]);
            end
        end
    endtask

    task automatic test_load_store();
        instruction_f = 32'h0081A103;  // lw x2,8(x3)
        step();
        tests++;
        if (b_imm_ext_e !== 32'h8 || ctrl !== 10'b1_0_0_0_1_01_000 || b_rd_e !== 5'd2) begin
            fails++; $display("FAIL lw: got imm %h ctrl %b rd %0d want 8 1000101000 2",
                              b_imm_ext_e, ctrl, b_rd_e);
        end
        instruction_f = 32'hFE51AE23;  // sw x5,-4(x3)
        step();
        tests++;
        if (b_imm_ext_e !== 32'hFFFFFFFC || ctrl !== 10'b0_1_0_0_1_00_000 || b_rs2_e !== 5'd5) begin
            fails++; $display("FAIL sw: got imm %h ctrl %b rs2 %0d want FFFFFFFC 0100100000 5",
                              b_imm_ext_e, ctrl, b_rs2_e);
        end
    endtask

    task automatic test_x0();
        instruction_f = 32'h00000233; reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'hDEAD;
        step();
        tests++;
        if (b_rd1_e !== 32'h0 || b_rd2_e !== 32'h0) begin
            fails++; $display("FAIL x0_same_cycle: got %h %h want 0 0", b_rd1_e, b_rd2_e);
        end
        reg_write_w = 1'b0;
        step();
        tests++;
        if (b_rd1_e !== 32'h0 || n_rd1_e !== 32'h0) begin
            fails++; $display("FAIL x0_after: got %h %h want 0 0", b_rd1_e, n_rd1_e);
        end
    endtask

    task automatic test_branch_flush();
        instruction_f = 32'hFE208CE3; pc_f = 32'h200; pc_plus_4_f = 32'h204;  // beq x1,x2,-8
        step();
        tests++;
        if (b_imm_ext_e !== 32'hFFFFFFF8 || ctrl !== 10'b0_0_0_1_0_00_001 || b_rd_e !== 5'd25) begin
            fails++; $display("FAIL beq: got imm %h ctrl %b rd %0d want FFFFFFF8 0001000001 25",
                              b_imm_ext_e, ctrl, b_rd_e);
        end
        flush_d = 1'b1;
        step();
        tests++;
        if (ctrl !== 10'd0 || b_rd_e !== 5'd0) begin
            fails++; $display("FAIL flush_d_beq: got ctrl %b rd %0d want 0 0", ctrl, b_rd_e);
        end
        instruction_f = 32'hFFB00093;
        step();
        tests++;
        if (ctrl !== 10'd0 || b_rd_e !== 5'd0) begin
            fails++; $display("FAIL flush_d_addi: got ctrl %b rd %0d want 0 0", ctrl, b_rd_e);
        end
        // flush_e wins over flush_d; write-back to x9 must still land.
        instruction_f = 32'hFE208CE3; flush_e = 1'b1;
        reg_write_w = 1'b1; rd_w = 5'd9; result_w = 32'h99;
        step();
        flush_d = 1'b0; flush_e = 1'b0; reg_write_w = 1'b0;
        tests++;
        if ({ctrl, b_rd1_e, b_rd2_e, b_imm_ext_e, b_pc_e, b_pc_plus_4_e, b_rs1_e, b_rs2_e, b_rd_e}
            !== 185'd0) begin
            fails++; $display("FAIL flush_e: got ctrl %b imm %h pc %h rs1 %0d want all 0",
                              ctrl, b_imm_ext_e, b_pc_e, b_rs1_e);
        end
        instruction_f = 32'h00948233;  // add x4,x9,x9
        step();
        tests++;
        if (n_rd1_e !== 32'h99 || b_rd2_e !== 32'h99) begin
            fails++; $display("FAIL wb_during_flush: got %h %h want 99 99", n_rd1_e, b_rd2_e);
        end
    endtask

    task automatic test_jal_nop();
        instruction_f = 32'h001000EF; pc_f = 32'h300; pc_plus_4_f = 32'h304;
        step();
        tests++;
        if (b_imm_ext_e !== 32'h800 || ctrl !== 10'b1_0_1_0_0_10_000 || b_rd_e !== 5'd1
            || b_pc_plus_4_e !== 32'h304) begin
            fails++; $display("FAIL jal: got imm %h ctrl %b rd %0d pc4 %h want 800 1010010000 1 304",
                              b_imm_ext_e, ctrl, b_rd_e, b_pc_plus_4_e);
        end
        instruction_f = 32'h0000007F;
        step();
        tests++;
        if (ctrl !== 10'd0 || n_ctrl !== 10'd0) begin
            fails++; $display("FAIL nop_opcode: got %b %b want 0 0", ctrl, n_ctrl);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_rtype_alu();
        test_load_store();
        test_x0();
        test_branch_flush();
        test_jal_nop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
